// File: rtl/ycr1_wbb_arb_pkg.sv
// ycr1_wbb_arb_pkg
//   Shared types and constants for the Wishbone burst arbiter.
//   - arb_state_t : arbiter FSM state (IDLE, BUSY)
//   - ARB_TOW_DEF : default watchdog counter width
//   - idx_w()     : index width for an N-entry one-hot vector (min 1)
package ycr1_wbb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_TOW_DEF = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ycr1_rr_pick.sv
// ycr1_rr_pick
//   Combinational round-robin picker. Selects the first requesting index
//   strictly after i_last_ptr, wrapping around NM.
//   Ports:
//     i_req      [NM-1:0]  request vector
//     i_last_ptr [IW-1:0]  index granted last time
//     o_gnt      [NM-1:0]  one-hot pick (0 when no request)
//     o_idx      [IW-1:0]  binary index of the pick
//     o_vld                any request present
module ycr1_rr_pick
  import ycr1_wbb_arb_pkg::*;
#(
  parameter int NM = 3,
  parameter int IW = idx_w(NM)
) (
  input  logic [NM-1:0] i_req,
  input  logic [IW-1:0] i_last_ptr,
  output logic [NM-1:0] o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  int w_j;

  // Walk from farthest to nearest so the nearest requester after
  // last_ptr overwrites any earlier hit.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = 0;
    for (int k = NM; k >= 1; k--) begin
      w_j = int'(i_last_ptr) + k;
      if (w_j >= NM) w_j = w_j - NM;
      if (i_req[w_j]) begin
        o_gnt = NM'(1) << w_j;
        o_idx = IW'(w_j);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ycr1_wbb_arb.sv
// ycr1_wbb_arb
//   Round-robin arbiter sharing one Wishbone burst master port among NM
//   requesters. One grant per transaction, held for the whole burst;
//   responses are steered only to the granted requester.
//   Optional watchdog: define YCR1_WBB_ARB_TIMEOUT_EN to enable a TOW-bit
//   stall counter that force-terminates a stuck burst with ack+lack+err.
//   Ports:
//     wbm_clk_i, wbm_rst_i          clock, async active-high reset
//     m_cyc_i/stb_i/we_i [NM]       requester control
//     m_adr_i/dat_i/sel_i/bl_i      requester payloads, packed per index
//     m_dat_o                       read data (broadcast)
//     m_ack_o/lack_o/err_o [NM]     per-requester responses
//     s_*_o                         downstream master port
//     s_dat_i/ack_i/lack_i/err_i    downstream responses
//     gnt_o [NM]                    registered one-hot grant
module ycr1_wbb_arb
  import ycr1_wbb_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BW  = 4,
  parameter int BL  = 10,
  parameter int NM  = 3,
  parameter int TOW = ARB_TOW_DEF
) (
  input  logic             wbm_clk_i,
  input  logic             wbm_rst_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*DW-1:0] m_dat_i,
  input  logic [NM*BW-1:0] m_sel_i,
  input  logic [NM*BL-1:0] m_bl_i,
  output logic [DW-1:0]    m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_lack_o,
  output logic [NM-1:0]    m_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [DW-1:0]    s_dat_o,
  output logic [BW-1:0]    s_sel_o,
  output logic [BL-1:0]    s_bl_o,
  input  logic [DW-1:0]    s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_lack_i,
  input  logic             s_err_i,
  output logic [NM-1:0]    gnt_o
);

  localparam int IW = idx_w(NM);

  arb_state_t    r_state, w_state_nxt;
  logic [NM-1:0] r_gnt;
  logic [IW-1:0] r_gidx;
  logic [IW-1:0] r_last_ptr;
  logic [BL-1:0] r_cnt;

  logic [NM-1:0] w_pick_gnt;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_vld;

  logic          w_busy, w_act, w_tmo;
  logic [BL-1:0] w_eff_bl;
  logic          w_last_beat, w_end;
  logic          w_ack, w_lack, w_err;
  logic          w_unused;

  ycr1_rr_pick #(.NM(NM), .IW(IW)) u_pick (
    .i_req      (m_stb_i),
    .i_last_ptr (r_last_ptr),
    .o_gnt      (w_pick_gnt),
    .o_idx      (w_pick_idx),
    .o_vld      (w_pick_vld)
  );

  // Strobe alone carries the request; cyc always brackets stb on this bus.
  assign w_unused = &{1'b0, m_cyc_i, TOW[0]};

  assign w_busy = (r_state == BUSY);
  // A granted requester that drops its strobe aborts: no bus cycle, no response.
  assign w_act  = w_busy & m_stb_i[r_gidx];

  assign s_adr_o = w_busy ? m_adr_i[r_gidx*AW +: AW] : '0;
  assign s_dat_o = w_busy ? m_dat_i[r_gidx*DW +: DW] : '0;
  assign s_sel_o = w_busy ? m_sel_i[r_gidx*BW +: BW] : '0;
  assign s_bl_o  = w_busy ? m_bl_i[r_gidx*BL +: BL]  : '0;
  assign s_we_o  = w_busy & m_we_i[r_gidx];

  // bl=0 behaves as a single beat.
  assign w_eff_bl    = (s_bl_o == '0) ? BL'(1) : s_bl_o;
  assign w_last_beat = (r_cnt == w_eff_bl - BL'(1));
  assign w_end       = s_ack_i & (s_lack_i | w_last_beat);

`ifdef YCR1_WBB_ARB_TIMEOUT_EN
  logic [TOW-1:0] r_tmo;
  assign w_tmo = w_act & (&r_tmo);

  always_ff @(posedge wbm_clk_i or posedge wbm_rst_i) begin
    if (wbm_rst_i)                   r_tmo <= '0;
    else if (!w_busy || s_ack_i)     r_tmo <= '0;
    else                             r_tmo <= r_tmo + TOW'(1);
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Watchdog cycle drops the bus and fakes a terminating error response.
  assign s_cyc_o = w_act & ~w_tmo;
  assign s_stb_o = w_act & ~w_tmo;

  assign w_ack  = w_act & (s_ack_i | w_tmo);
  assign w_lack = w_act & (w_end | w_tmo);
  assign w_err  = w_act & (s_err_i | w_tmo);

  assign m_ack_o  = w_ack  ? r_gnt : '0;
  assign m_lack_o = w_lack ? r_gnt : '0;
  assign m_err_o  = w_err  ? r_gnt : '0;
  assign m_dat_o  = s_dat_i;
  assign gnt_o    = r_gnt;

  always_ff @(posedge wbm_clk_i or posedge wbm_rst_i) begin
    if (wbm_rst_i) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_pick_vld) w_state_nxt = BUSY;
      BUSY: if (!m_stb_i[r_gidx] || w_tmo || s_err_i || w_end)
              w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wbm_clk_i or posedge wbm_rst_i) begin
    if (wbm_rst_i) begin
      r_gnt      <= '0;
      r_gidx     <= '0;
      r_last_ptr <= IW'(NM-1);
      r_cnt      <= '0;
    end else if (!w_busy) begin
      if (w_pick_vld) begin
        r_gnt      <= w_pick_gnt;
        r_gidx     <= w_pick_idx;
        r_last_ptr <= w_pick_idx;
        r_cnt      <= '0;
      end
    end else if (w_state_nxt == IDLE) begin
      r_gnt <= '0;
    end else if (s_ack_i) begin
      r_cnt <= r_cnt + BL'(1);
    end
  end

endmodule

// File: doc/ycr1_wbb_arb.md
# ycr1_wbb_arb

Round-robin arbiter sharing one Wishbone burst master port between NM requesters, e.g. the icache, dcache and debug masters. The arbiter sits in the core clock domain, upstream of the async Wishbone burst bridge. It grants one requester per transaction and holds the grant for the whole burst. Responses are steered only to the granted requester. A beat counter and an optional watchdog guarantee that the grant is always released.

## Interface
- AW, 32, address width
- DW, 32, data width
- BW, 4, byte-select width
- BL, 10, burst-count width (1 = one DW beat)
- NM, 3, number of requesters
- TOW, 8, watchdog counter width (used only with the macro)

Ports:
- wbm_clk_i  in  1  core clock
- wbm_rst_i  in  1  reset, asynchronous, active-high
- m_cyc_i  in  NM  per-requester cycle
- m_stb_i  in  NM  per-requester strobe
- m_adr_i  in  NM*AW  addresses, requester i at [i*AW +: AW]
- m_we_i  in  NM  write enables
- m_dat_i  in  NM*DW  write data
- m_sel_i  in  NM*BW  byte selects
- m_bl_i  in  NM*BL  burst counts
- m_dat_o  out  DW  read data, broadcast to all requesters
- m_ack_o  out  NM  per-requester ack
- m_lack_o  out  NM  per-requester last ack
- m_err_o  out  NM  per-requester error
- s_cyc_o, s_stb_o, s_we_o  out  1  downstream control
- s_adr_o  out  AW  downstream address
- s_dat_o  out  DW  downstream write data
- s_sel_o  out  BW  downstream byte selects
- s_bl_o  out  BL  downstream burst count
- s_dat_i  in  DW  downstream read data
- s_ack_i  in  1  downstream ack
- s_lack_i  in  1  downstream last ack
- s_err_i  in  1  downstream error
- gnt_o  out  NM  one-hot registered grant (status)

## Operation
- FSM states:
  - IDLE: s_cyc_o and s_stb_o are 0. If any m_stb_i bit is set, pick the first requesting index strictly after last_ptr (wrapping), register gnt_o and last_ptr, and go to BUSY.
  - BUSY: the granted requester's adr, we, dat, sel and bl are muxed combinationally onto s_*; s_cyc_o = s_stb_o = m_stb_i[g]. s_ack_i, s_err_i and the lack term are routed only to index g; all other m_ack_o, m_lack_o and m_err_o bits are 0.
- Beat counter (BL bits): cleared on grant, incremented on each s_ack_i in BUSY. last_beat = (cnt == eff_bl-1), where eff_bl = (s_bl_o==0) ? 1 : s_bl_o.
- m_lack_o[g] = s_ack_i & (s_lack_i | last_beat).
- BUSY goes to IDLE on any of:
  - s_ack_i & (s_lack_i | last_beat)
  - s_err_i
  - m_stb_i[g]==0 (abort): no response is generated and gnt_o clears.
- The IDLE cycle between transactions guarantees the ≥1-cycle strobe-low gap required downstream.
- m_dat_o = s_dat_i at all times.

## Timing
- Reset: all outputs 0, state IDLE, last_ptr = NM-1, so requester 0 wins first. Assertion mid-burst drops s_stb_o and gnt_o immediately (asynchronous); no response is generated.
- Grant latency: m_stb_i rises in cycle n → gnt_o and s_stb_o high in cycle n+1.
- Transaction end → IDLE in the next cycle → next grant one cycle later. Back-to-back cost is one bubble cycle.
- Requests that arrive during BUSY wait; arbitration samples m_stb_i only in IDLE.
- Simultaneous requests: the round-robin order is strict, so no requester waits more than NM-1 transactions.
- Ack responses are combinational pass-through: zero added latency.
- Beat counter wraps only at its BL-bit modulus. s_lack_i ends the burst first whenever it arrives.

## Configuration
- YCR1_WBB_ARB_TIMEOUT_EN defined:
  - A TOW-bit counter runs in BUSY; it clears on grant and on each s_ack_i.
  - When the counter reaches all-ones, the arbiter pulses m_ack_o[g], m_lack_o[g] and m_err_o[g] together for one cycle, forces s_cyc_o and s_stb_o to 0 that cycle, and returns to IDLE.
- YCR1_WBB_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; TOW is ignored.

## Structure
- Package ycr1_wbb_arb_pkg: FSM state enum (IDLE, BUSY), default timeout width constant.
- Sub-module ycr1_rr_pick: combinational NM-wide round-robin picker (req vector and last_ptr in, one-hot grant and index out), reusable by other arbiters.

## Test plan
- Single read, requester 1, bl=1: s_stb_o high one cycle after m_stb_i[1]; one s_ack_i → m_ack_o[1]=m_lack_o[1]=1; gnt_o=0 the next cycle.
- All three requesting from reset: grants in order 0,1,2,0. Each burst has bl=4; grant stays held for exactly 4 acks with one bubble between bursts.
- Burst bl=8 where the slave never asserts s_lack_i: the 8th ack produces m_lack_o and releases the grant.
- bl=0 write: treated as one beat; the first ack ends the transaction.
- s_err_i on beat 2 of a bl=4 read: m_err_o pulses for the granted requester only; FSM returns to IDLE.
- With the macro defined and TOW=4: the slave stalls 15 cycles after grant → simultaneous ack/lack/err pulse, s_stb_o low, next requester granted.
